// File: rtl/burst_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_rd_pkg
// Description : Shared types and helpers for the burst read master.
//               Holds the controller state encoding and an unsigned minimum
//               helper used by the burst length calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Unsigned minimum of two 32-bit quantities.
    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/burst_rd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : burst_rd_master_if
// Description : Avalon-MM burst read bus between the read master and memory.
//               master modport : drives address/read/burstcount,
//                                receives readdata/readdatavalid/waitrequest.
//               slave modport  : the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface burst_rd_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 16
);
    logic [ADDR_W-1:0]  address;
    logic               read;
    logic [BURST_W-1:0] burstcount;
    logic [DATA_W-1:0]  readdata;
    logic               readdatavalid;
    logic               waitrequest;

    modport master (
        output address, read, burstcount,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, burstcount,
        output readdata, readdatavalid, waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/burst_len_calc.sv
`default_nettype none
// ============================================================================
// Module      : burst_len_calc
// Description : Combinational length of the next burst.
//               rem       : remaining words of the transfer
//               word_addr : current address in DATA_W words
//               blen      : beats for the next burst
//               Build option BURST_BOUNDARY_EN additionally limits the burst
//               so it stops at the next MAX_BURST-word aligned boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_len_calc
    import burst_rd_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int BURST_W   = 16
) (
    input  wire logic [LEN_W-1:0]   rem,
    input  wire logic [ADDR_W-1:0]  word_addr,
    output logic      [BURST_W-1:0] blen
);

    logic [31:0] w_rem32;
    logic [31:0] w_cap;

    assign w_rem32 = 32'(rem);

`ifdef BURST_BOUNDARY_EN
    // Words left before the next aligned MAX_BURST boundary. MAX_BURST is a
    // power of two, so the modulo is a mask of the low word-address bits.
    logic [31:0] w_room;
    assign w_room = 32'(MAX_BURST) - (32'(word_addr) & 32'(MAX_BURST - 1));
    assign w_cap  = min_u32(32'(MAX_BURST), w_room);
`else
    logic w_unused_word_addr;
    assign w_unused_word_addr = ^word_addr;
    assign w_cap = 32'(MAX_BURST);
`endif

    assign blen = BURST_W'(min_u32(w_rem32, w_cap));

endmodule
`default_nettype wire

// File: rtl/burst_rd_master.sv
`default_nettype none
// ============================================================================
// Module      : burst_rd_master
// Description : Avalon-MM burst read master streaming a contiguous memory
//               region into a downstream FIFO, one burst outstanding.
//   clk, reset           : clock, synchronous active-high reset
//   start                : request pulse (IDLE only)
//   start_addr, length   : byte address / byte count captured on start
//   busy, done           : in progress / one-cycle completion pulse
//   fifo_almost_full     : back-pressure, checked before each burst
//   fifo_data, fifo_wr   : registered read data and write strobe
//   avm                  : Avalon host command / response bus (master)
//   Build option BURST_BOUNDARY_EN: bursts never cross a
//   MAX_BURST*DATA_W/8-byte aligned boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_rd_master
    import burst_rd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int BURST_W   = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] start_addr,
    input  wire logic [LEN_W-1:0]  length,
    output logic                   busy,
    output logic                   done,
    input  wire logic              fifo_almost_full,
    output logic      [DATA_W-1:0] fifo_data,
    output logic                   fifo_wr,
    burst_rd_master_if.master      avm
);

    localparam int c_byte_shift = $clog2(DATA_W / 8);

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_rem;
    logic [BURST_W-1:0] r_blen;
    logic [BURST_W-1:0] r_beats;
    logic               r_read;
    logic [ADDR_W-1:0]  r_address;
    logic [BURST_W-1:0] r_burstcount;
    logic [DATA_W-1:0]  r_fifo_data;
    logic               r_fifo_wr;

    logic [LEN_W-1:0]   w_len_words;
    logic [ADDR_W-1:0]  w_word_addr;
    logic [BURST_W-1:0] w_blen;
    logic [LEN_W-1:0]   w_rem_after;
    logic               w_capture;
    logic               w_launch;
    logic               w_accept;
    logic               w_beat;
    logic               w_last;

    assign w_len_words = length >> c_byte_shift;
    assign w_word_addr = r_addr >> c_byte_shift;
    assign w_rem_after = r_rem - LEN_W'(r_blen);

    burst_len_calc #(
        .LEN_W     (LEN_W),
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST),
        .BURST_W   (BURST_W)
    ) u_len_calc (
        .rem       (r_rem),
        .word_addr (w_word_addr),
        .blen      (w_blen)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_launch    = 1'b0;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (w_len_words == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Back-pressure only gates raising read; an issued command
                // is held until the slave takes it.
                if (!r_read && !fifo_almost_full) begin
                    w_launch = 1'b1;
                end else if (r_read && !avm.waitrequest) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (avm.readdatavalid) begin
                    w_beat = 1'b1;
                    if (r_beats == BURST_W'(1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = (w_rem_after == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, counters and bus command registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_rem        <= '0;
            r_blen       <= '0;
            r_beats      <= '0;
            r_read       <= 1'b0;
            r_address    <= '0;
            r_burstcount <= '0;
            r_fifo_data  <= '0;
            r_fifo_wr    <= 1'b0;
        end else begin
            r_fifo_data <= avm.readdata;
            r_fifo_wr   <= w_beat;

            if (w_capture) begin
                r_addr <= start_addr;
                r_rem  <= w_len_words;
            end

            if (w_launch) begin
                r_read       <= 1'b1;
                r_address    <= r_addr;
                r_burstcount <= w_blen;
                r_blen       <= w_blen;
            end

            if (w_accept) begin
                r_read  <= 1'b0;
                r_beats <= r_blen;
            end

            if (w_beat) begin
                if (w_last) begin
                    r_rem   <= w_rem_after;
                    r_addr  <= r_addr + (ADDR_W'(r_blen) << c_byte_shift);
                    r_beats <= '0;
                end else begin
                    r_beats <= r_beats - BURST_W'(1);
                end
            end
        end
    end

    assign avm.address    = r_address;
    assign avm.read       = r_read;
    assign avm.burstcount = r_burstcount;
    assign fifo_data      = r_fifo_data;
    assign fifo_wr        = r_fifo_wr;
    assign busy           = (r_state == ST_ISSUE) || (r_state == ST_DATA);
    assign done           = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_burst_rd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_rd_master
// Description : Self-checking bench for burst_rd_master. A memory slave
//               answers Avalon bursts; a reference model derives the expected
//               command list and FIFO data stream from start address/length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_rd_master;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 16;
    localparam int MAX_BURST = 16;
    localparam int BURST_W   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] start_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        fifo_almost_full;
    logic [31:0] fifo_data;
    logic        fifo_wr;

    burst_rd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) avm ();

    burst_rd_master #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST),
        .BURST_W   (BURST_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .fifo_almost_full (fifo_almost_full),
        .fifo_data        (fifo_data),
        .fifo_wr          (fifo_wr),
        .avm              (avm)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    // ------------------------------------------------------------------
    // Memory slave
    // ------------------------------------------------------------------
    int          ws_max   = 0;
    bit          ws_rand  = 0;
    bit          gaps_en  = 0;
    bit          afull_rand = 0;
    logic [31:0] beats_q[$];
    logic [31:0] cmd_addr_q[$];
    int          cmd_bc_q[$];
    int          stab_viol = 0;

    initial begin
        int          wait_cnt;
        int          ws_cur;
        logic [31:0] held_addr;
        logic [15:0] held_bc;
        wait_cnt = 0;
        ws_cur   = 0;
        held_addr = '0;
        held_bc   = '0;
        avm.waitrequest   = 1'b0;
        avm.readdatavalid = 1'b0;
        avm.readdata      = '0;
        forever begin
            @(negedge clk);
            // Beats are served before any new command is recorded, so the
            // first beat always follows the accepting edge.
            if (beats_q.size() > 0 && (!gaps_en || $urandom_range(0, 2) != 0)) begin
                avm.readdatavalid = 1'b1;
                avm.readdata      = beats_q.pop_front();
            end else begin
                avm.readdatavalid = 1'b0;
                avm.readdata      = $urandom;
            end
            if (avm.read) begin
                if (wait_cnt == 0) begin
                    held_addr = avm.address;
                    held_bc   = avm.burstcount;
                    ws_cur    = ws_rand ? int'($urandom_range(0, ws_max)) : ws_max;
                end else if (avm.address !== held_addr || avm.burstcount !== held_bc) begin
                    stab_viol++;
                end
                if (wait_cnt < ws_cur) begin
                    avm.waitrequest = 1'b1;
                    wait_cnt++;
                end else begin
                    avm.waitrequest = 1'b0;
                    wait_cnt = 0;
                    cmd_addr_q.push_back(avm.address);
                    cmd_bc_q.push_back(int'(avm.burstcount));
                    for (int i = 0; i < int'(avm.burstcount); i++)
                        beats_q.push_back(mem_word(avm.address + 32'(i * 4)));
                end
            end else begin
                avm.waitrequest = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (afull_rand) fifo_almost_full = ($urandom_range(0, 3) == 0);
        end
    end

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic [31:0] obs_q[$];
    int          rise_q[$];
    int          done_cnt = 0;
    logic        done_wr, done_busy;
    int          done_words;
    bit          busy_seen = 0, read_seen = 0;
    int          afull_viol = 0;

    initial begin
        logic afull_s;
        logic prev_read;
        prev_read = 1'b0;
        forever begin
            @(posedge clk);
            afull_s = fifo_almost_full;
            cyc++;
            #1;
            if (!reset) begin
                if (avm.read && !prev_read) begin
                    rise_q.push_back(cyc);
                    if (afull_s) afull_viol++;
                end
                if (fifo_wr) obs_q.push_back(fifo_data);
                if (done) begin
                    done_cnt++;
                    done_wr    = fifo_wr;
                    done_busy  = busy;
                    done_words = obs_q.size();
                end
                if (busy) busy_seen = 1;
                if (avm.read) read_seen = 1;
            end
            prev_read = avm.read;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: burst list and data stream of a transfer
    // ------------------------------------------------------------------
    logic [31:0] exp_addr_q[$];
    int          exp_bc_q[$];
    logic [31:0] exp_data_q[$];

    task automatic build_expect(input logic [31:0] addr, input logic [15:0] len);
        int          words;
        int          room;
        int          b;
        logic [31:0] a;
        exp_addr_q.delete();
        exp_bc_q.delete();
        exp_data_q.delete();
        words = int'(len) / 4;
        a     = addr;
        while (words > 0) begin
            room = MAX_BURST;
`ifdef BURST_BOUNDARY_EN
            room = MAX_BURST - int'((a >> 2) & 32'(MAX_BURST - 1));
`endif
            b = words;
            if (b > MAX_BURST) b = MAX_BURST;
            if (b > room) b = room;
            exp_addr_q.push_back(a);
            exp_bc_q.push_back(b);
            for (int i = 0; i < b; i++) exp_data_q.push_back(mem_word(a + 32'(4 * i)));
            words -= b;
            a = a + 32'(4 * b);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        cmd_addr_q.delete();
        cmd_bc_q.delete();
        rise_q.delete();
        done_cnt   = 0;
        busy_seen  = 0;
        read_seen  = 0;
        stab_viol  = 0;
        afull_viol = 0;
        done_wr    = 1'b0;
        done_busy  = 1'b0;
        done_words = 0;
    endtask

    task automatic launch(input logic [31:0] addr, input logic [15:0] len, output logic busy_after);
        @(negedge clk);
        start      = 1'b1;
        start_addr = addr;
        length     = len;
        @(negedge clk);
        start      = 1'b0;
        start_addr = $urandom;
        length     = 16'($urandom);
        busy_after = busy;
    endtask

    task automatic wait_done(input string name, input int budget, output int waited);
        waited = 0;
        while (done_cnt == 0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check_eq({name, ".done_timeout"}, 64'(done_cnt != 0), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_expect(input string name);
        int n;
        check_eq({name, ".ncmd"}, 64'(cmd_addr_q.size()), 64'(exp_addr_q.size()));
        n = (cmd_addr_q.size() < exp_addr_q.size()) ? cmd_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq({name, ".cmd_addr"}, 64'(cmd_addr_q[i]), 64'(exp_addr_q[i]));
            check_eq({name, ".cmd_bc"}, 64'(cmd_bc_q[i]), 64'(exp_bc_q[i]));
        end
        check_eq({name, ".nwords"}, 64'(obs_q.size()), 64'(exp_data_q.size()));
        n = (obs_q.size() < exp_data_q.size()) ? obs_q.size() : exp_data_q.size();
        for (int i = 0; i < n; i++)
            check_eq({name, ".data"}, 64'(obs_q[i]), 64'(exp_data_q[i]));
        check_eq({name, ".done_cnt"}, 64'(done_cnt), 64'd1);
        if (exp_data_q.size() > 0) begin
            check_eq({name, ".done_with_wr"}, 64'(done_wr), 64'd1);
            check_eq({name, ".busy_at_done"}, 64'(done_busy), 64'd0);
            check_eq({name, ".words_at_done"}, 64'(done_words), 64'(exp_data_q.size()));
        end
        check_eq({name, ".cmd_stable"}, 64'(stab_viol), 64'd0);
        check_eq({name, ".afull_rise"}, 64'(afull_viol), 64'd0);
    endtask

    task automatic run_xfer(input string name, input logic [31:0] addr, input logic [15:0] len, input bit poke);
        logic b;
        int   waited;
        clear_obs();
        build_expect(addr, len);
        launch(addr, len, b);
        check_eq({name, ".busy_after_start"}, 64'(b), 64'(exp_data_q.size() > 0));
        if (poke) begin
            // A start while busy must be ignored.
            repeat (3) @(negedge clk);
            start      = 1'b1;
            start_addr = $urandom & 32'hFFFF_FFFC;
            length     = 16'd40;
            @(negedge clk);
            start      = 1'b0;
        end
        wait_done(name, 3000, waited);
        compare_expect(name);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic        b;
        int          waited;
        int          release_cyc;
        int          guard;
        logic [31:0] ra;

        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        length = '0;
        fifo_almost_full = 1'b0;
        release_cyc = 0;

        repeat (3) @(negedge clk);
        check_eq("rst.address", 64'(avm.address), 64'd0);
        check_eq("rst.read", 64'(avm.read), 64'd0);
        check_eq("rst.burstcount", 64'(avm.burstcount), 64'd0);
        check_eq("rst.fifo_data", 64'(fifo_data), 64'd0);
        check_eq("rst.fifo_wr", 64'(fifo_wr), 64'd0);
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Base case
        run_xfer("base", 32'h1000, 16'd64, 0);
        check_eq("base.addr0", 64'(cmd_addr_q[0]), 64'h1000);
        check_eq("base.bc0", 64'(cmd_bc_q[0]), 64'd16);

        // Split transfer with wait states and an ignored start
        ws_max = 3;
        run_xfer("split", 32'h1000, 16'd88, 1);
        check_eq("split.bc0", 64'(cmd_bc_q[0]), 64'd16);
        check_eq("split.addr1", 64'(cmd_addr_q[1]), 64'h1040);
        check_eq("split.bc1", 64'(cmd_bc_q[1]), 64'd6);
        ws_max = 0;

        // Back-pressure ahead of the second burst
        clear_obs();
        build_expect(32'h3000, 16'd128);
        launch(32'h3000, 16'd128, b);
        guard = 0;
        while (cmd_addr_q.size() < 1 && guard < 200) begin @(negedge clk); guard++; end
        fifo_almost_full = 1'b1;
        guard = 0;
        while (obs_q.size() < 16 && guard < 200) begin @(negedge clk); guard++; end
        repeat (10) @(negedge clk);
        release_cyc = cyc;
        check_eq("bp.no_read_while_full", 64'(rise_q.size()), 64'd1);
        fifo_almost_full = 1'b0;
        wait_done("bp", 3000, waited);
        compare_expect("bp");
        check_eq("bp.resume_after_release", 64'(rise_q.size() == 2 && rise_q[1] > release_cyc), 64'd1);

        // Zero length
        clear_obs();
        build_expect(32'h4000, 16'd3);
        launch(32'h4000, 16'd3, b);
        check_eq("zero.busy_after_start", 64'(b), 64'd0);
        wait_done("zero", 5, waited);
        check_eq("zero.done_latency", 64'(waited <= 1), 64'd1);
        check_eq("zero.done_cnt", 64'(done_cnt), 64'd1);
        check_eq("zero.busy_seen", 64'(busy_seen), 64'd0);
        check_eq("zero.read_seen", 64'(read_seen), 64'd0);

        // Boundary
        run_xfer("bound", 32'h1038, 16'd64, 0);
`ifdef BURST_BOUNDARY_EN
        check_eq("bound.ncmd_fixed", 64'(cmd_bc_q.size()), 64'd2);
        check_eq("bound.bc0", 64'(cmd_bc_q[0]), 64'd2);
        check_eq("bound.bc1", 64'(cmd_bc_q[1]), 64'd14);
`else
        check_eq("bound.ncmd_fixed", 64'(cmd_bc_q.size()), 64'd1);
        check_eq("bound.bc0", 64'(cmd_bc_q[0]), 64'd16);
`endif

        // Address wrap past the top of the space
        run_xfer("wrap", 32'hFFFF_FFC0, 16'd128, 0);

        // Reset in the middle of a burst
        clear_obs();
        launch(32'h2000, 16'd64, b);
        guard = 0;
        while (obs_q.size() < 5 && guard < 200) begin @(negedge clk); guard++; end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_rst.address", 64'(avm.address), 64'd0);
        check_eq("mid_rst.read", 64'(avm.read), 64'd0);
        check_eq("mid_rst.burstcount", 64'(avm.burstcount), 64'd0);
        check_eq("mid_rst.fifo_data", 64'(fifo_data), 64'd0);
        check_eq("mid_rst.fifo_wr", 64'(fifo_wr), 64'd0);
        check_eq("mid_rst.busy", 64'(busy), 64'd0);
        check_eq("mid_rst.done", 64'(done), 64'd0);
        reset = 1'b0;
        guard = 0;
        while (beats_q.size() > 0 && guard < 200) begin @(negedge clk); guard++; end
        repeat (4) @(negedge clk);
        check_eq("mid_rst.wr_count", 64'(obs_q.size()), 64'd5);
        check_eq("mid_rst.no_done", 64'(done_cnt), 64'd0);
        check_eq("mid_rst.no_new_read", 64'(rise_q.size()), 64'd1);
        run_xfer("post_rst", 32'h5000, 16'd64, 0);

        // Randomized transfers with wait states, gaps and back-pressure
        ws_max = 3;
        ws_rand = 1;
        gaps_en = 1;
        afull_rand = 1;
        for (int t = 0; t < 6; t++) begin
            ra = $urandom & 32'hFFFF_FFFC;
            run_xfer("rnd", ra, 16'($urandom_range(0, 400)), 0);
        end
        afull_rand = 0;
        fifo_almost_full = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
